// File: rtl/munoc_ahb_master_network_interface_core_if.sv
// Signal bundle between the local AHB master, the AHB-to-AXI master bridge
// and the MUNOC network-side node.
//   master : the bridge's view (AHB slave side in, AXI request channels out)
//   slave  : the surroundings' view (AHB master and network node)
interface munoc_ahb_master_network_interface_core_if #(
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 32,
    parameter int BW_TID  = 4
);
    logic                 hsel;
    logic                 hwrite;
    logic                 hready;
    logic [1:0]           htrans;
    logic [2:0]           hsize;
    logic [2:0]           hburst;
    logic [3:0]           hprot;
    logic [BW_ADDR-1:0]   haddr;
    logic [BW_DATA-1:0]   hwdata;
    logic                 hreadyout;
    logic                 hresp;
    logic [BW_DATA-1:0]   hrdata;

    logic                 awvalid;
    logic                 awready;
    logic [BW_TID-1:0]    awid;
    logic [BW_ADDR-1:0]   awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;

    logic                 wvalid;
    logic                 wready;
    logic [BW_DATA-1:0]   wdata;
    logic [BW_DATA/8-1:0] wstrb;
    logic                 wlast;

    logic                 bvalid;
    logic                 bready;
    logic [BW_TID-1:0]    bid;
    logic [1:0]           bresp;

    logic                 arvalid;
    logic                 arready;
    logic [BW_TID-1:0]    arid;
    logic [BW_ADDR-1:0]   araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;

    logic                 rvalid;
    logic                 rready;
    logic [BW_TID-1:0]    rid;
    logic [BW_DATA-1:0]   rdata;
    logic [1:0]           rresp;
    logic                 rlast;

    modport master (
        input  hsel, hwrite, hready, htrans, hsize, hburst, hprot, haddr, hwdata,
        output hreadyout, hresp, hrdata,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        output hsel, hwrite, hready, htrans, hsize, hburst, hprot, haddr, hwdata,
        input  hreadyout, hresp, hrdata,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/munoc_ahb_master_network_interface_core.sv
// AHB-Lite slave port to single-beat AXI-style AW/W/AR requests toward the
// MUNOC packetizer, one transfer outstanding at a time.
// Optional feature macro: MUNOC_AHB_MASTER_NI_POSTED_WRITE_EN
//   defined   -> writes complete after AW+W; B is awaited in the background
//   undefined -> writes complete only after B
//
// state | meaning
// IDLE  | no data phase pending; hreadyout=1, may capture an address phase
// WRITE | issuing AW and W, each dropped after its own handshake
// BWAIT | waiting for the write response
// READ  | issuing AR until arready
// RWAIT | waiting for the read beat
// ERR1  | first ERROR cycle (hreadyout=0, hresp=1)
// ERR2  | second ERROR cycle (hreadyout=1, hresp=1), may capture
module munoc_ahb_master_network_interface_core #(
    parameter int                BW_ADDR    = 32,
    parameter int                BW_DATA    = 32,
    parameter int                BW_TID     = 4,
    parameter logic [BW_TID-1:0] MASTER_TID = '0
) (
    input logic clk,
    input logic rstnn,
    munoc_ahb_master_network_interface_core_if.master bus
);
    localparam int         BW_STRB  = BW_DATA / 8;
    localparam int         OFF_W    = $clog2(BW_STRB);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    typedef enum logic [2:0] {IDLE, WRITE, BWAIT, READ, RWAIT, ERR1, ERR2} state_t;

    state_t               state_q, state_d;
    logic [BW_ADDR-1:0]   addr_q;
    logic [2:0]           size_q;
    logic [BW_STRB-1:0]   strb_q;
    logic [BW_DATA-1:0]   hrdata_q;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                 pend_q, pend_d;
    logic                 awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                 capture, size_ok, can_capture;
    logic                 aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                 unused_inputs;

    // Byte lanes touched by an aligned access: lanes sharing the same
    // 2^size-byte block as the address offset.
    function automatic logic [BW_STRB-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                     input logic [2:0] size);
        logic [BW_STRB-1:0] m;
        m = '0;
        for (int i = 0; i < BW_STRB; i++)
            m[i] = ((i >> size) == (int'(off) >> size));
        return m;
    endfunction

    assign capture     = bus.hsel && bus.hready && bus.htrans[1];
    assign size_ok     = (bus.hsize <= MAX_SIZE);
    assign can_capture = (state_q == IDLE) || (state_q == ERR2);
    assign aw_hs       = awvalid_q && bus.awready;
    assign w_hs        = wvalid_q && bus.wready;
    assign ar_hs       = arvalid_q && bus.arready;
    assign b_hs        = bready_q && bus.bvalid;
    assign r_hs        = rready_q && bus.rvalid;

    // Next-state decode, channel-done tracking and the posted-write B flag.
    always_comb begin
        state_d   = state_q;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        pend_d    = 1'b0;
`ifdef MUNOC_AHB_MASTER_NI_POSTED_WRITE_EN
        pend_d    = pend_q && !b_hs;
`endif
        case (state_q)
            IDLE, ERR2: begin
                state_d = IDLE;
                if (capture) begin
                    if (!size_ok)        state_d = ERR1;
                    else if (bus.hwrite) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            WRITE: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
`ifdef MUNOC_AHB_MASTER_NI_POSTED_WRITE_EN
                    state_d = IDLE;
                    pend_d  = 1'b1;
`else
                    state_d = BWAIT;
`endif
                end
            end
            BWAIT:   if (b_hs) state_d = bus.bresp[1] ? ERR1 : IDLE;
            READ:    if (ar_hs) state_d = RWAIT;
            RWAIT:   if (r_hs) state_d = bus.rresp[1] ? ERR1 : IDLE;
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered network handshake outputs; requests are
    // held back while a posted write still owes its B beat.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            pend_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            pend_q    <= pend_d;
            awvalid_q <= (state_d == WRITE) && !aw_done_d && !pend_d;
            wvalid_q  <= (state_d == WRITE) && !w_done_d && !pend_d;
            arvalid_q <= (state_d == READ) && !pend_d;
            bready_q  <= (state_d == BWAIT) || pend_d;
            rready_q  <= (state_d == RWAIT);
        end
    end

    // Address-phase capture and read-data register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            addr_q   <= '0;
            size_q   <= '0;
            strb_q   <= '0;
            hrdata_q <= '0;
        end else begin
            if (can_capture && capture) begin
                addr_q <= bus.haddr;
                size_q <= bus.hsize;
                strb_q <= lane_mask(bus.haddr[OFF_W-1:0], bus.hsize);
            end
            if (r_hs)
                hrdata_q <= bus.rdata;
        end
    end

    assign bus.hreadyout = can_capture;
    assign bus.hresp     = (state_q == ERR1) || (state_q == ERR2);
    assign bus.hrdata    = hrdata_q;

    assign bus.awvalid = awvalid_q;
    assign bus.awid    = MASTER_TID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = size_q;
    assign bus.awburst = 2'b01;

    // hwdata is stable for the whole data phase because hreadyout is low.
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = bus.hwdata;
    assign bus.wstrb   = strb_q;
    assign bus.wlast   = 1'b1;

    assign bus.bready  = bready_q;

    assign bus.arvalid = arvalid_q;
    assign bus.arid    = MASTER_TID;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = size_q;
    assign bus.arburst = 2'b01;

    assign bus.rready  = rready_q;

    assign unused_inputs = ^{bus.hburst, bus.hprot, bus.htrans[0], bus.bid, bus.rid,
                             bus.bresp[0], bus.rresp[0], bus.rlast};
endmodule
